// File: rtl/tt_um_count_checker.sv
// tt_um_count_checker: checks a peer 8-bit counter stream (hold when stopped, else +1 mod 256), locks and counts errors
module tt_um_count_checker #(
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  state_t state, state_d;
  logic [7:0] cur_q, prev_q, err_cnt, bad_val, exp_val;
  logic [3:0] good_cnt;
  logic stop_q, prev_stop, have_prev, sticky_err, wrap_q;
  logic en, clr, match, good, bad, err_upd;
  logic unused;
  assign unused = &{1'b0, ena, uio_in[7:4]};
  assign en = uio_in[1];
  assign clr = uio_in[2];
  assign exp_val = prev_q + {7'd0, ~prev_stop};
  assign match = cur_q == exp_val;
  assign good = have_prev && match;
  assign bad = have_prev && !match;
  assign err_upd = en && state == LOCKED && bad;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (!en) state_d = IDLE;
    else if (state == IDLE) state_d = ACQUIRE;
    else if (state == ACQUIRE && good && good_cnt == 4'(LOCK_COUNT - 1)) state_d = LOCKED;
    else if (state == LOCKED && bad) state_d = ACQUIRE;
  end
  // have_prev stays low for the first sample after IDLE so it is never judged
  always_ff @(posedge clk)
    if (!rst_n) begin
      cur_q <= '0;
      prev_q <= '0;
      stop_q <= 1'b0;
      prev_stop <= 1'b0;
      have_prev <= 1'b0;
      good_cnt <= '0;
      wrap_q <= 1'b0;
      err_cnt <= '0;
      sticky_err <= 1'b0;
      bad_val <= '0;
    end else begin
      cur_q <= ui_in;
      stop_q <= uio_in[0];
      prev_q <= cur_q;
      prev_stop <= stop_q;
      have_prev <= en && state != IDLE;
      good_cnt <= (!en || state == IDLE || (state == ACQUIRE && bad) || err_upd) ? '0 :
                  (state == ACQUIRE && good) ? good_cnt + 4'd1 : good_cnt;
      wrap_q <= en && state == LOCKED && good && prev_q == 8'hFF && cur_q == 8'h00;
      err_cnt <= clr ? '0 : (err_upd && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
      sticky_err <= !clr && (sticky_err || err_upd);
      bad_val <= clr ? '0 : err_upd ? cur_q : bad_val;
    end
  always_comb begin
    uo_out = uio_in[3] ? bad_val : err_cnt;
    uio_out = {wrap_q, state == ACQUIRE, sticky_err, state == LOCKED, 4'h0};
    uio_oe = 8'hF0;
  end
endmodule

// File: tb/tb_tt_um_count_checker.sv
// tb_tt_um_count_checker: directed stream scoreboard for the counter checker tile
module tb_tt_um_count_checker;
  logic clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  logic [7:0] v;
  int edges = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    string name;
    logic [7:0] uo;
    logic [7:0] uio;
    bit chk_uo;
  } exp_t;
  exp_t sb[$];

  tt_um_count_checker #(.LOCK_COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rn, input logic en, input logic stp, input logic [7:0] ui,
                      input logic clr = 1'b0, input logic sel = 1'b0);
    @(negedge clk);
    #1;
    rst_n = rn;
    ui_in = ui;
    uio_in = {4'h0, sel, clr, en, stp};
    @(posedge clk);
    edges++;
  endtask

  task automatic exp_at(input string n, input logic [7:0] uo, input logic [7:0] uio, input bit cu = 1'b1);
    exp_t e;
    e.cyc = edges;
    e.name = n;
    e.uo = uo;
    e.uio = uio;
    e.chk_uo = cu;
    sb.push_back(e);
  endtask

  // monitor: inputs are stable from negedge+1 to the next negedge, so posedge+2 sees settled outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc <= edges) begin
        e = sb.pop_front();
        checks++;
        if ((e.chk_uo && uo_out !== e.uo) || uio_out !== e.uio || uio_oe !== 8'hF0) begin
          errors++;
          $display("FAIL %s @edge %0d: got uo=%h uio=%h oe=%h, want uo=%h uio=%h oe=f0",
                   e.name, edges, uo_out, uio_out, uio_oe, e.uo, e.uio);
        end
      end
    end
  end

  initial begin
    ena = 1'b1;
    rst_n = 1'b0;
    ui_in = '0;
    uio_in = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      ui_in = 8'($urandom);
      uio_in = 8'($urandom);
      @(posedge clk);
      edges++;
      exp_at("reset", 8'h00, 8'h00);
    end
    step(1, 1, 0, 8'h10);
    exp_at("acq_start", 8'h00, 8'h40);
    for (int i = 1; i < 5; i++) begin
      step(1, 1, 0, 8'h10 + 8'(i));
      exp_at("acquiring", 8'h00, 8'h40);
    end
    step(1, 1, 0, 8'h15);
    exp_at("locked", 8'h00, 8'h10);
    v = 8'h15;
    while (v != 8'hFD) begin
      v++;
      step(1, 1, 0, v);
    end
    exp_at("run_locked", 8'h00, 8'h10);
    step(1, 1, 0, 8'hFE);
    step(1, 1, 1, 8'hFF);
    exp_at("hold_in", 8'h00, 8'h10);
    step(1, 1, 0, 8'hFF);
    exp_at("hold_ok", 8'h00, 8'h10);
    step(1, 1, 0, 8'h00);
    exp_at("hold_cmp", 8'h00, 8'h10);
    step(1, 1, 0, 8'h01);
    exp_at("wrap", 8'h00, 8'h90);
    step(1, 1, 0, 8'h02);
    exp_at("wrap_end", 8'h00, 8'h10);
    v = 8'h02;
    while (v != 8'h3F) begin
      v++;
      step(1, 1, 0, v);
    end
    step(1, 1, 0, 8'h42);
    exp_at("pre_err", 8'h00, 8'h10);
    step(1, 1, 0, 8'h43);
    exp_at("err_cnt", 8'h01, 8'h60);
    step(1, 1, 0, 8'h44, 0, 1);
    exp_at("bad_val", 8'h42, 8'h60);
    step(1, 1, 0, 8'h45);
    step(1, 1, 0, 8'h46);
    exp_at("reacq", 8'h01, 8'h60);
    step(1, 1, 0, 8'h47);
    exp_at("relock", 8'h01, 8'h30);
    v = 8'h47;
    for (int i = 0; i < 300; i++) begin
      for (int k = 2; k <= 7; k++) step(1, 1, 0, v + 8'(k));
      v = v + 8'd7;
      if (i == 252) exp_at("sat_fe", 8'hFE, 8'h30);
      if (i == 253) exp_at("sat_ff", 8'hFF, 8'h30);
    end
    exp_at("sat_hold", 8'hFF, 8'h30);
    step(1, 1, 0, v + 8'd2);
    step(1, 1, 0, v + 8'd3, 1, 0);
    exp_at("clr_on_err", 8'h00, 8'h40);
    step(1, 1, 0, v + 8'd4, 0, 1);
    exp_at("clr_badval", 8'h00, 8'h40);
    step(1, 1, 0, v + 8'd5, 1, 0);
    step(1, 1, 0, v + 8'd6);
    exp_at("clr_acq", 8'h00, 8'h40);
    step(1, 1, 0, v + 8'd7);
    exp_at("clr_relock", 8'h00, 8'h10);
    v = v + 8'd7;
    step(1, 1, 0, v + 8'd2);
    step(1, 1, 0, v + 8'd3);
    exp_at("err2", 8'h01, 8'h60);
    for (int k = 4; k <= 7; k++) step(1, 1, 0, v + 8'(k));
    exp_at("err2_relock", 8'h01, 8'h30);
    step(1, 0, 0, 8'h5A);
    exp_at("disable", 8'h01, 8'h20);
    step(1, 0, 0, 8'hA5);
    exp_at("idle_hold", 8'h01, 8'h20);
    step(1, 1, 0, 8'h80);
    exp_at("reenable", 8'h01, 8'h60);
    step(1, 1, 0, 8'h81);
    exp_at("first_sample", 8'h01, 8'h60);
    step(1, 1, 0, 8'h82);
    step(1, 1, 0, 8'h83);
    step(1, 1, 0, 8'h84);
    exp_at("reen_acq", 8'h01, 8'h60);
    step(1, 1, 0, 8'h85);
    exp_at("reen_lock", 8'h01, 8'h30);
    step(0, 1, 0, 8'h86, 1, 0);
    exp_at("rst_locked", 8'h00, 8'h00);
    step(1, 0, 0, 8'h00);
    exp_at("rst_err", 8'h00, 8'h00);
    step(1, 0, 0, 8'h00, 0, 1);
    exp_at("rst_badval", 8'h00, 8'h00);
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
